// File: rtl/ticket_vend_ctrl.sv
// Ticket vending transaction sequencer: fee latch, coin balance, one-cycle ticket, one-coin-per-ack change/refund.
// Optional build macro TVC_TIMEOUT_EN adds an idle auto-refund out of COLLECT after TIMEOUT_CYC cycles.
module ticket_vend_ctrl #(
    parameter int BAL_W       = 6,
    parameter int TIMEOUT_CYC = 1000,
    parameter int TO_W        = 16
) (
    input  logic             clk,
    input  logic             res,
    input  logic             sel,
    input  logic [3:0]       fee,
    input  logic             ci1,
    input  logic             ci5,
    input  logic             ci10,
    input  logic             cancel,
    input  logic             chg_ack,
    output logic             ticket,
    output logic             chg5,
    output logic             chg1,
    output logic             coin_rej,
    output logic             done,
    output logic             timeout,
    output logic             busy,
    output logic [BAL_W-1:0] balance,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_CHANGE  = 2'd3
    } state_t;

    state_t           state_q, state_nxt;
    logic [BAL_W-1:0] bal_q, bal_nxt, coin_val, fee_ext;
    logic [3:0]       fee_q, fee_nxt;
    logic             coin_any, covered, to_hit, to_fire;
    logic             coin_rej_q, done_q, timeout_q;

    // Catch a timeout constant that does not fit the counter.
    if (TIMEOUT_CYC >= (1 << TO_W)) begin : g_bad_timeout_cfg
        $error("TIMEOUT_CYC does not fit in TO_W bits");
    end

    assign coin_any = ci1 | ci5 | ci10;
    assign coin_val = (ci1  ? BAL_W'(1)  : '0)
                    + (ci5  ? BAL_W'(5)  : '0)
                    + (ci10 ? BAL_W'(10) : '0);
    assign fee_ext  = BAL_W'(fee_q);
    assign covered  = (bal_q >= fee_ext);

`ifdef TVC_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    // Held at zero outside COLLECT, so every entry into COLLECT starts from zero.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            to_cnt <= '0;
        end else if (state_q != S_COLLECT || coin_any) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_W'(TIMEOUT_CYC)) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign to_hit = (state_q == S_COLLECT) && (to_cnt == TO_W'(TIMEOUT_CYC));
`else
    assign to_hit = 1'b0;
`endif

    // Cancel and a covered fee both outrank the idle timeout.
    assign to_fire = to_hit && !cancel && !covered;

    always_comb begin
        state_nxt = state_q;
        bal_nxt   = bal_q;
        fee_nxt   = fee_q;
        case (state_q)
            S_IDLE: begin
                if (sel && fee != 4'd0) begin
                    fee_nxt   = fee;
                    bal_nxt   = '0;
                    state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                bal_nxt = bal_q + coin_val;
                if (cancel)       state_nxt = S_CHANGE;
                else if (covered) state_nxt = S_VEND;
                else if (to_fire) state_nxt = S_CHANGE;
            end
            S_VEND: begin
                bal_nxt   = bal_q - fee_ext;
                state_nxt = S_CHANGE;
            end
            S_CHANGE: begin
                if (bal_q == '0) begin
                    state_nxt = S_IDLE;
                end else if (chg_ack) begin
                    bal_nxt = chg5 ? (bal_q - BAL_W'(5)) : (bal_q - BAL_W'(1));
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q    <= S_IDLE;
            bal_q      <= '0;
            fee_q      <= '0;
            coin_rej_q <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            bal_q      <= bal_nxt;
            fee_q      <= fee_nxt;
            coin_rej_q <= coin_any && (state_q != S_COLLECT);
            done_q     <= (state_q == S_CHANGE) && (bal_q == '0);
            timeout_q  <= to_fire;
        end
    end

    assign ticket   = (state_q == S_VEND);
    assign chg5     = (state_q == S_CHANGE) && (bal_q >= BAL_W'(5));
    assign chg1     = (state_q == S_CHANGE) && (bal_q != '0) && (bal_q < BAL_W'(5));
    assign busy     = (state_q != S_IDLE);
    assign coin_rej = coin_rej_q;
    assign done     = done_q;
    assign timeout  = timeout_q;
    assign balance  = bal_q;
    assign state    = state_q;

endmodule

// File: tb/tb_ticket_vend_ctrl.sv
// Directed bench for ticket_vend_ctrl: reset, exact pay, change, cancel, boundaries, idle timeout.
module tb_ticket_vend_ctrl;

    logic       clk = 1'b0;
    logic       res;
    logic       sel, ci1, ci5, ci10, cancel, chg_ack;
    logic [3:0] fee;
    logic       ticket, chg5, chg1, coin_rej, done, timeout, busy;
    logic [5:0] balance;
    logic [1:0] state;

    int tests_run = 0;
    int tests_failed = 0;
    int n5, n1, both, pay_cyc, saw_ticket, saw_to;

    ticket_vend_ctrl #(.BAL_W(6), .TIMEOUT_CYC(20), .TO_W(16)) dut (
        .clk(clk), .res(res), .sel(sel), .fee(fee),
        .ci1(ci1), .ci5(ci5), .ci10(ci10), .cancel(cancel), .chg_ack(chg_ack),
        .ticket(ticket), .chg5(chg5), .chg1(chg1), .coin_rej(coin_rej),
        .done(done), .timeout(timeout), .busy(busy), .balance(balance), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        if (ticket) saw_ticket++;
    endtask

    task automatic start(input logic [3:0] f);
        sel = 1'b1; fee = f;
        tick;
        sel = 1'b0; fee = 4'd0;
    endtask

    task automatic coin(input logic c1, input logic c5, input logic c10);
        ci1 = c1; ci5 = c5; ci10 = c10;
        tick;
        ci1 = 1'b0; ci5 = 1'b0; ci10 = 1'b0;
    endtask

    // Acks each request on the following cycle until the DUT leaves CHANGE.
    task automatic pay_out;
        n5 = 0; n1 = 0; both = 0; pay_cyc = 0;
        for (int i = 0; i < 20 && state == 2'd3; i++) begin
            if (chg5) n5++;
            if (chg1) n1++;
            if (chg5 && chg1) both++;
            chg_ack = chg5 | chg1;
            tick;
            chg_ack = 1'b0;
            pay_cyc++;
        end
    endtask

    initial begin
        res = 1'b0; sel = 1'b0; fee = 4'd0; ci1 = 1'b0; ci5 = 1'b0; ci10 = 1'b0;
        cancel = 1'b0; chg_ack = 1'b0; saw_ticket = 0; saw_to = 0;

        // Reset with a coin present
        ci10 = 1'b1;
        repeat (2) tick;
        check("rst_state", state, 0);
        check("rst_balance", balance, 0);
        check("rst_outs", {ticket, chg5, chg1, coin_rej, done, timeout, busy}, 0);
        ci10 = 1'b0;
        res = 1'b1;
        tick;
        check("rst_release_bal", balance, 0);
        check("rst_release_rej", coin_rej, 0);

        // sel with fee 0 ignored
        start(4'd0);
        check("fee0_ignored", state, 0);

        // Exact payment: fee 6 = 5 + 1
        saw_ticket = 0;
        start(4'd6);
        check("exact_collect", state, 1);
        check("exact_busy", busy, 1);
        coin(1'b0, 1'b1, 1'b0);
        check("exact_bal5", balance, 5);
        coin(1'b1, 1'b0, 1'b0);
        check("exact_bal6", balance, 6);
        tick;
        check("exact_vend", state, 2);
        check("exact_ticket", ticket, 1);
        tick;
        check("exact_change_state", state, 3);
        check("exact_change_bal", balance, 0);
        pay_out;
        check("exact_chg5", n5, 0);
        check("exact_chg1", n1, 0);
        check("exact_pay_cyc", pay_cyc, 1);
        check("exact_done", done, 1);
        check("exact_idle", state, 0);
        check("exact_ticket_cnt", saw_ticket, 1);
        tick;
        check("exact_done_once", done, 0);

        // Change payout: fee 3, pay 10 -> change 7
        saw_ticket = 0;
        start(4'd3);
        coin(1'b0, 1'b0, 1'b1);
        check("chg_bal10", balance, 10);
        tick;
        check("chg_ticket", ticket, 1);
        tick;
        check("chg_bal7", balance, 7);
        check("chg_req5", chg5, 1);
        pay_out;
        check("chg_n5", n5, 1);
        check("chg_n1", n1, 2);
        check("chg_excl", both, 0);
        check("chg_pay_cyc", pay_cyc, 4);
        check("chg_done", done, 1);
        check("chg_bal0", balance, 0);
        check("chg_ticket_cnt", saw_ticket, 1);

        // Cancel: fee 15, pay 11, cancel -> refund 5+5+1
        saw_ticket = 0;
        start(4'd15);
        coin(1'b0, 1'b0, 1'b1);
        coin(1'b1, 1'b0, 1'b0);
        check("cxl_bal11", balance, 11);
        cancel = 1'b1;
        tick;
        cancel = 1'b0;
        check("cxl_state", state, 3);
        pay_out;
        check("cxl_n5", n5, 2);
        check("cxl_n1", n1, 1);
        check("cxl_done", done, 1);
        check("cxl_no_ticket", saw_ticket, 0);

        // Simultaneous ci5+ci10, then a coin during VEND
        start(4'd15);
        coin(1'b0, 1'b1, 1'b1);
        check("sim_bal15", balance, 15);
        tick;
        check("sim_vend", state, 2);
        coin(1'b1, 1'b0, 1'b0);
        check("vend_coin_rej", coin_rej, 1);
        check("vend_coin_bal", balance, 0);
        pay_out;
        check("sim_n", n5 + n1, 0);
        check("sim_done", done, 1);

        // Cancel in the cycle the fee becomes covered
        saw_ticket = 0;
        start(4'd5);
        cancel = 1'b1;
        coin(1'b0, 1'b1, 1'b0);
        cancel = 1'b0;
        check("cxl_cov_state", state, 3);
        check("cxl_cov_bal", balance, 5);
        pay_out;
        check("cxl_cov_n5", n5, 1);
        check("cxl_cov_no_ticket", saw_ticket, 0);

        // chg_ack and a coin in IDLE
        chg_ack = 1'b1;
        coin(1'b1, 1'b0, 1'b0);
        chg_ack = 1'b0;
        check("idle_ack_state", state, 0);
        check("idle_ack_bal", balance, 0);
        check("idle_coin_rej", coin_rej, 1);
        tick;
        check("idle_coin_rej_clr", coin_rej, 0);

        // Reset while chg5 is high
        start(4'd1);
        coin(1'b0, 1'b0, 1'b1);
        tick;
        tick;
        check("mid_rst_chg5_pre", chg5, 1);
        #2 res = 1'b0;
        #1;
        check("mid_rst_chg5", chg5, 0);
        check("mid_rst_bal", balance, 0);
        check("mid_rst_state", state, 0);
        tick;
        res = 1'b1;
        tick;
        check("mid_rst_no_done", done, 0);

        // Idle timeout in COLLECT (TIMEOUT_CYC = 20)
        start(4'd9);
        coin(1'b0, 1'b1, 1'b0);
`ifdef TVC_TIMEOUT_EN
        for (int i = 0; i < 40 && !timeout; i++) tick;
        check("to_pulse", timeout, 1);
        check("to_state", state, 3);
        check("to_bal", balance, 5);
        tick;
        check("to_pulse_once", timeout, 0);
        pay_out;
        check("to_n5", n5, 1);
        check("to_done", done, 1);
`else
        for (int i = 0; i < 25; i++) begin
            tick;
            if (timeout) saw_to++;
        end
        check("noto_state", state, 1);
        check("noto_bal", balance, 5);
        check("noto_pulse", saw_to, 0);
        cancel = 1'b1;
        tick;
        cancel = 1'b0;
        pay_out;
        check("noto_n5", n5, 1);
        check("noto_done", done, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
